sram_ctrl: RTL and testbench

- Memory-side stage directly downstream of the memory-access pipeline stage.
- Accepts that stage's word-aligned read/write request (address, write data, byte enables) and runs a multi-cycle access on the external asynchronous 32-bit SRAM.
- Holds the pipeline with a stall while the access is in flight, then returns the read word.

---
 rtl/sram_ctrl_pkg.sv | 14 +
 rtl/sram_byte_merge.sv | 13 +
 rtl/sram_ctrl.sv | 159 +++++++++++++++
 tb/tb_sram_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared state encodings and defaults for the external async SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    SRAM_ST_IDLE     = 2'd0,
    SRAM_ST_ACCESS   = 2'd1,
    SRAM_ST_DONE     = 2'd2,
    SRAM_ST_RMW_READ = 2'd3
  } sram_st_e;

  localparam int         SRAM_WAIT_CYCLES_DEFAULT = 2;
  localparam logic [3:0] SRAM_BE_ALL              = 4'hF;

endpackage

// File: rtl/sram_byte_merge.sv
// Combinational byte-lane merge: lane i takes the new word when be_i[i] is set, else the old word.
module sram_byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  be_i,
  output logic [31:0] merged_o
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign merged_o[8*g +: 8] = be_i[g] ? new_i[8*g +: 8] : old_i[8*g +: 8];
  end

endmodule

// File: rtl/sram_ctrl.sv
// Multi-cycle async SRAM access for the memory stage; stalls WAIT_CYCLES+1 cycles per access
// (2*WAIT_CYCLES+1 for partial writes when SRAM_CTRL_RMW_EN is defined), read data valid in DONE.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES_DEFAULT,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_access_read,
  input  logic              mem_access_write,
  input  logic [31:0]       mem_access_addr,
  input  logic [31:0]       mem_access_data,
  input  logic [3:0]        mem_byte_en,
  input  logic              alignment_err,
  output logic [31:0]       mem_read_data,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_data_o,
  output logic              sram_data_oe,
  input  logic [31:0]       sram_data_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  sram_st_e          state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        be_q, be_d;
  logic              wr_q, wr_d;
  logic              req;
  logic              unused_addr_bits;

  assign req              = (mem_access_read | mem_access_write) & ~alignment_err;
  assign unused_addr_bits = ^{mem_access_addr[31:ADDR_W+2], mem_access_addr[1:0]};

`ifdef SRAM_CTRL_RMW_EN
  logic [31:0] merged;

  sram_byte_merge u_merge (
    .old_i    (sram_data_i),
    .new_i    (wdata_q),
    .be_i     (be_q),
    .merged_o (merged)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    case (state_q)
      SRAM_ST_IDLE: begin
        if (req) begin
          // write wins when both request lines are high
          addr_d  = mem_access_addr[ADDR_W+1:2];
          wdata_d = mem_access_data;
          wr_d    = mem_access_write;
          be_d    = mem_access_write ? mem_byte_en : SRAM_BE_ALL;
          cnt_d   = CNT_LOAD;
          state_d = SRAM_ST_ACCESS;
`ifdef SRAM_CTRL_RMW_EN
          if (mem_access_write && (mem_byte_en != SRAM_BE_ALL)) state_d = SRAM_ST_RMW_READ;
`endif
        end
      end
      SRAM_ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) rdata_d = sram_data_i;
          state_d = SRAM_ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef SRAM_CTRL_RMW_EN
      SRAM_ST_RMW_READ: begin
        if (cnt_q == 4'd0) begin
          // the write phase then drives a full word with every lane enabled
          wdata_d = merged;
          be_d    = SRAM_BE_ALL;
          cnt_d   = CNT_LOAD;
          state_d = SRAM_ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      SRAM_ST_DONE: state_d = SRAM_ST_IDLE;
      default:      state_d = SRAM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SRAM_ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      be_q    <= 4'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
    end
  end

  // Strobes decode registered state only; WE rises one cycle before CE so addr/data hold past it.
  always_comb begin
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_be_n    = 4'hF;
    sram_data_oe = 1'b0;
    sram_data_o  = wdata_q;
    sram_addr    = addr_q;
    case (state_q)
      SRAM_ST_ACCESS: begin
        sram_ce_n = 1'b0;
        sram_be_n = ~be_q;
        if (wr_q) begin
          sram_data_oe = 1'b1;
          sram_we_n    = (cnt_q == 4'd0);
        end else begin
          sram_oe_n = 1'b0;
        end
      end
`ifdef SRAM_CTRL_RMW_EN
      SRAM_ST_RMW_READ: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = 4'h0;
      end
`endif
      default: ;
    endcase
  end

  assign mem_stall     = ((state_q == SRAM_ST_IDLE) && req) || (state_q == SRAM_ST_ACCESS)
                       || (state_q == SRAM_ST_RMW_READ);
  assign mem_read_data = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with an SRAM part model and a cycle-level reference model.
module tb_sram_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_access_read, mem_access_write, alignment_err;
  logic [31:0] mem_access_addr, mem_access_data;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_read_data;
  logic        mem_stall;
  logic [19:0] sram_addr;
  logic [31:0] sram_data_o, sram_data_i;
  logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  always #5 clk = ~clk;

  sram_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .mem_access_read  (mem_access_read),
    .mem_access_write (mem_access_write),
    .mem_access_addr  (mem_access_addr),
    .mem_access_data  (mem_access_data),
    .mem_byte_en      (mem_byte_en),
    .alignment_err    (alignment_err),
    .mem_read_data    (mem_read_data),
    .mem_stall        (mem_stall),
    .sram_addr        (sram_addr),
    .sram_data_o      (sram_data_o),
    .sram_data_oe     (sram_data_oe),
    .sram_data_i      (sram_data_i),
    .sram_ce_n        (sram_ce_n),
    .sram_oe_n        (sram_oe_n),
    .sram_we_n        (sram_we_n),
    .sram_be_n        (sram_be_n)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Physical SRAM part: drives data while selected and output-enabled, stores while WE is low.
  logic [31:0] sram_mem [256];
  logic [31:0] ref_mem  [256];

  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 32'h0;

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_data_oe)
      sram_mem[sram_addr[7:0]] <= merge(sram_mem[sram_addr[7:0]], sram_data_o, ~sram_be_n);

  // Observation counters, cleared by the stimulus before each operation.
  int          c_stall, c_oe, c_we, c_doe, c_ce, c_start;
  logic [19:0] seen_addr;
  logic [3:0]  seen_be;
  logic        prev_ce_n = 1'b1;

  task automatic clr();
    c_stall = 0; c_oe = 0; c_we = 0; c_doe = 0; c_ce = 0; c_start = 0;
    seen_addr = '0; seen_be = 4'hF;
  endtask

  // Reference model: m_t = 0 idle, 1..m_L access cycles, m_L+1 the single DONE cycle.
  int          m_t = 0;
  int          m_L = W;
  logic        m_wr = 1'b0, m_rmw = 1'b0;
  logic [19:0] m_addr = '0;
  logic [31:0] m_wdata = '0, m_merged = '0, m_rdword = '0, m_rdata = '0;
  logic [3:0]  m_be = '0;

  always @(negedge clk) begin
    logic        req, e_stall, e_ce, e_oe, e_we, e_doe;
    logic [3:0]  e_be;
    logic [31:0] e_dat;
    int          j;
    req     = (mem_access_read | mem_access_write) & ~alignment_err;
    e_stall = 1'b0; e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_doe = 1'b0;
    e_be    = 4'hF; e_dat = '0;
    if (m_t == 0) begin
      e_stall = req;
    end else if (m_t <= m_L) begin
      e_stall = 1'b1;
      e_ce    = 1'b0;
      if (m_rmw && m_t <= W) begin
        e_oe = 1'b0; e_be = 4'h0;
      end else if (m_wr) begin
        j     = m_rmw ? m_t - W : m_t;
        e_doe = 1'b1;
        e_we  = (j == W);
        e_be  = m_rmw ? 4'h0 : ~m_be;
        e_dat = m_rmw ? m_merged : m_wdata;
      end else begin
        e_oe = 1'b0; e_be = 4'h0;
      end
    end
    chk("stall", {31'b0, mem_stall}, {31'b0, e_stall});
    chk("ce_n", {31'b0, sram_ce_n}, {31'b0, e_ce});
    chk("oe_n", {31'b0, sram_oe_n}, {31'b0, e_oe});
    chk("we_n", {31'b0, sram_we_n}, {31'b0, e_we});
    chk("data_oe", {31'b0, sram_data_oe}, {31'b0, e_doe});
    chk("be_n", {28'b0, sram_be_n}, {28'b0, e_be});
    chk("rdata", mem_read_data, m_rdata);
    if (!e_ce) chk("addr", {12'b0, sram_addr}, {12'b0, m_addr});
    if (e_doe) chk("wdata", sram_data_o, e_dat);

    if (mem_stall)                  c_stall++;
    if (!sram_ce_n)                 c_ce++;
    if (!sram_ce_n && !sram_oe_n)   c_oe++;
    if (!sram_ce_n && !sram_we_n)   c_we++;
    if (sram_data_oe)               c_doe++;
    if (!sram_ce_n && prev_ce_n)    c_start++;
    if (!sram_ce_n)                 seen_addr = sram_addr;
    if (sram_data_oe)               seen_be = sram_be_n;
    prev_ce_n = sram_ce_n;

    // advance with the inputs the coming rising edge will sample
    if (rst) begin
      m_t = 0; m_rdata = '0;
    end else if (m_t == 0) begin
      if (req) begin
        m_wr   = mem_access_write;
        m_addr = mem_access_addr[21:2];
        m_be   = mem_access_write ? mem_byte_en : 4'hF;
        m_wdata = mem_access_data;
`ifdef SRAM_CTRL_RMW_EN
        m_rmw = m_wr && (m_be != 4'hF);
`else
        m_rmw = 1'b0;
`endif
        m_L = m_rmw ? 2 * W : W;
        if (m_wr) begin
          m_merged = merge(ref_mem[mem_access_addr[9:2]], mem_access_data, m_be);
          ref_mem[mem_access_addr[9:2]] = m_merged;
        end else begin
          m_rdword = ref_mem[mem_access_addr[9:2]];
        end
        m_t = 1;
      end
    end else if (m_t <= m_L) begin
      if (m_t == m_L && !m_wr) m_rdata = m_rdword;
      m_t++;
    end else begin
      m_t = 0;
    end
  end

  task automatic idle_inputs();
    mem_access_read = 1'b0; mem_access_write = 1'b0; alignment_err = 1'b0;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be, input logic ae, output logic [31:0] rdat);
    int n;
    clr();
    mem_access_read = rd; mem_access_write = wr; mem_access_addr = a;
    mem_access_data = d; mem_byte_en = be; alignment_err = ae;
    @(posedge clk); #1;
    idle_inputs();
    rdat = '0;
    if (ae) begin
      repeat (3) @(posedge clk);
      #1;
    end else begin
      n = 0;
      while (mem_stall && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk("done_reached", {31'b0, ~mem_stall}, 32'd1);
      rdat = mem_read_data;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    idle_inputs();
    mem_access_addr = '0; mem_access_data = '0; mem_byte_en = 4'hF;
    for (int i = 0; i < 256; i++) sram_mem[i] = 32'hC0DE_0000 | i;
    sram_mem[4]  = 32'hDEAD_BEEF;
    sram_mem[16] = 32'h1111_1111;
    for (int i = 0; i < 256; i++) ref_mem[i] = sram_mem[i];
    clr();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
    chk("rst_rdata", mem_read_data, 32'd0);

    op(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, r);
    chk("rd_data", r, 32'hDEAD_BEEF);
    chk("rd_stall_cycles", c_stall, 32'd3);
    chk("rd_oe_cycles", c_oe, 32'd2);
    chk("rd_addr", {12'b0, seen_addr}, 32'd4);

    op(1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 1'b0, r);
    chk("wr_we_cycles", c_we, 32'd1);
    chk("wr_doe_cycles", c_doe, 32'd2);
    op(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, r);
    chk("wr_readback", r, 32'h1234_5678);

    op(1'b0, 1'b1, 32'h40, 32'hAAAA_AAAA, 4'b0100, 1'b0, r);
`ifdef SRAM_CTRL_RMW_EN
    chk("bw_be_n", {28'b0, seen_be}, 32'h0);
    chk("bw_stall_cycles", c_stall, 32'd5);
`else
    chk("bw_be_n", {28'b0, seen_be}, 32'hB);
    chk("bw_stall_cycles", c_stall, 32'd3);
`endif
    op(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, r);
    chk("bw_readback", r, 32'h11AA_1111);

    op(1'b0, 1'b1, 32'h50, 32'hFFFF_FFFF, 4'hF, 1'b1, r);
    chk("ae_stall_cycles", c_stall, 32'd0);
    chk("ae_ce_cycles", c_ce, 32'd0);
    op(1'b1, 1'b0, 32'h50, 32'h0, 4'hF, 1'b0, r);
    chk("ae_readback", r, 32'hC0DE_0014);

    // two full access periods (IDLE + W ACCESS + DONE each) with read held high
    clr();
    mem_access_read = 1'b1; mem_access_addr = 32'h10; mem_byte_en = 4'hF;
    repeat (2 * (W + 2)) @(posedge clk);
    #1 idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_starts", c_start, 32'd2);
    chk("b2b_stall_cycles", c_stall, 32'd6);

    // reset during the second access cycle of a write
    clr();
    mem_access_write = 1'b1; mem_access_addr = 32'h30;
    mem_access_data = 32'h5A5A_5A5A; mem_byte_en = 4'hF;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("mid_rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
    chk("mid_rst_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("mid_rst_rdata", mem_read_data, 32'd0);
    op(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, r);
    chk("mid_rst_readback", r, 32'h5A5A_5A5A);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
